// File: rtl/cpu_pkg.sv
// Shared CPU control definitions: sequence-counter geometry and run-state encoding.
package cpu_pkg;

    localparam int SC_W    = 3;
    localparam int SC_LAST = 7;
    localparam int T_N     = 1 << SC_W;
    localparam int ICNT_W  = 16;

    typedef enum logic [1:0] {
        ST_HALTED = 2'd0,
        ST_RUN    = 2'd1,
        ST_STEP   = 2'd2
    } sc_state_t;

endpackage

// File: rtl/seq_counter_sc_decoder.sv
// Combinational one-hot decode of the T-state number.
module sc_decoder
    import cpu_pkg::*;
(
    input  logic [SC_W-1:0] sc,
    output logic [T_N-1:0]  t_onehot
);

    always_comb begin
        t_onehot     = '0;
        t_onehot[sc] = 1'b1;
    end

endmodule

// File: rtl/seq_counter.sv
// T-state sequence counter with run/step/halt control, memory-stall hold,
// retired-instruction count and a sticky wrap-without-clear error flag.
module seq_counter
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              halt_req,
    input  logic              step_req,
    input  logic              sc_clr,
    input  logic              mem_busy,
    input  logic              mem_ready,
    output logic [SC_W-1:0]   sc,
    output logic [T_N-1:0]    t_onehot,
    output logic              fetch,
    output logic              halted,
    output logic [ICNT_W-1:0] instr_count,
    output logic              sc_err
);

    sc_state_t state;
    sc_state_t state_nx;
    logic      halt_pend;
    logic      running;
    logic      stall;
    logic      advance;
    logic      at_last;
    logic      boundary;

    assign running  = (state != ST_HALTED);
    assign stall    = running & mem_busy & ~mem_ready;
    assign advance  = running & ~stall;
    assign at_last  = (sc == SC_W'(SC_LAST));
    assign boundary = advance & (sc_clr | at_last);

    always_comb begin
        state_nx = state;
        case (state)
            ST_HALTED: begin
                // halt_req has priority: neither start nor step may leave HALTED while it is high
                if (!halt_req) begin
                    if (start)         state_nx = ST_RUN;
                    else if (step_req) state_nx = ST_STEP;
                end
            end
            ST_RUN: begin
                if (boundary && (halt_pend || halt_req)) state_nx = ST_HALTED;
            end
            ST_STEP: begin
                if (boundary) state_nx = ST_HALTED;
            end
            default: state_nx = ST_HALTED;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_HALTED;
            sc          <= '0;
            instr_count <= '0;
            sc_err      <= 1'b0;
            halt_pend   <= 1'b0;
        end else begin
            state <= state_nx;

            if (!running)      sc <= '0;
            else if (boundary) sc <= '0;
            else if (advance)  sc <= sc + SC_W'(1);

            if (boundary) instr_count <= instr_count + ICNT_W'(1);

            if (boundary && at_last && !sc_clr) sc_err <= 1'b1;

            // Pending halt survives stalls and is dropped whenever RUN is left
            if (state == ST_RUN && state_nx == ST_RUN) halt_pend <= halt_pend | halt_req;
            else                                       halt_pend <= 1'b0;
        end
    end

    assign fetch  = running & (sc == '0);
    assign halted = ~running;

    sc_decoder u_sc_decoder (
        .sc       (sc),
        .t_onehot (t_onehot)
    );

endmodule

// File: tb/tb_seq_counter.sv
// Bench for seq_counter: directed scenarios plus randomized traffic against a behavioural model.
module tb_seq_counter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        halt_req = 1'b0;
    logic        step_req = 1'b0;
    logic        sc_clr = 1'b0;
    logic        mem_busy = 1'b0;
    logic        mem_ready = 1'b0;
    logic [2:0]  sc;
    logic [7:0]  t_onehot;
    logic        fetch;
    logic        halted;
    logic [15:0] instr_count;
    logic        sc_err;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: mode 0 = halted, 1 = run, 2 = single step
    int m_mode  = 0;
    int m_sc    = 0;
    int m_cnt   = 0;
    bit m_err   = 0;
    bit m_pend  = 0;
    bit m_valid = 0;

    seq_counter dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .halt_req    (halt_req),
        .step_req    (step_req),
        .sc_clr      (sc_clr),
        .mem_busy    (mem_busy),
        .mem_ready   (mem_ready),
        .sc          (sc),
        .t_onehot    (t_onehot),
        .fetch       (fetch),
        .halted      (halted),
        .instr_count (instr_count),
        .sc_err      (sc_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) begin
            m_mode = 0; m_sc = 0; m_cnt = 0; m_err = 0; m_pend = 0; m_valid = 1;
        end else if (m_valid) begin
            if (m_mode == 0) begin
                if (!halt_req && start)         m_mode = 1;
                else if (!halt_req && step_req) m_mode = 2;
            end else begin
                if (m_mode == 1 && halt_req) m_pend = 1;
                if (!(mem_busy && !mem_ready)) begin
                    if (sc_clr || m_sc == 7) begin
                        m_cnt = (m_cnt + 1) % 65536;
                        if (m_sc == 7 && !sc_clr) m_err = 1;
                        m_sc = 0;
                        if (m_mode == 2 || m_pend) begin
                            m_mode = 0;
                            m_pend = 0;
                        end
                    end else begin
                        m_sc = m_sc + 1;
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Single compare process against the model, away from the active edge
    always @(negedge clk) begin
        if (m_valid) begin
            chk("m_sc",       int'(sc),          m_sc);
            chk("m_onehot",   int'(t_onehot),    (1 << m_sc));
            chk("m_fetch",    int'(fetch),       int'(m_mode != 0 && m_sc == 0));
            chk("m_halted",   int'(halted),      int'(m_mode == 0));
            chk("m_icount",   int'(instr_count), m_cnt);
            chk("m_sc_err",   int'(sc_err),      int'(m_err));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_sc"},     int'(sc),          0);
        chk({tag, "_onehot"}, int'(t_onehot),    1);
        chk({tag, "_fetch"},  int'(fetch),       0);
        chk({tag, "_halted"}, int'(halted),      1);
        chk({tag, "_icount"}, int'(instr_count), 0);
        chk({tag, "_sc_err"}, int'(sc_err),      0);
    endtask

    initial begin
        int guard;
        tick();
        // Reset, start pulse, instruction cleared at T4
        rst = 1'b1; tick(); rst = 1'b0;
        chk_reset_values("rst");
        start = 1'b1; tick(); start = 1'b0;
        chk("start_sc0", int'(sc), 0);
        chk("start_fetch", int'(fetch), 1);
        tick(); chk("start_sc1", int'(sc), 1);
        tick(); tick(); tick();
        chk("run_sc4", int'(sc), 4);
        sc_clr = 1'b1; tick(); sc_clr = 1'b0;
        chk("clr_sc0", int'(sc), 0);
        chk("clr_fetch", int'(fetch), 1);
        chk("clr_icount", int'(instr_count), 1);

        // Stall at T2 for three cycles with a stray sc_clr
        tick(); tick();
        chk("pre_stall_sc2", int'(sc), 2);
        mem_busy = 1'b1; mem_ready = 1'b0;
        tick(); chk("stall1_sc", int'(sc), 2);
        sc_clr = 1'b1; tick(); sc_clr = 1'b0;
        chk("stall2_sc", int'(sc), 2);
        tick(); chk("stall3_sc", int'(sc), 2);
        mem_busy = 1'b0;
        tick(); chk("post_stall_sc", int'(sc), 3);

        // Halt request latched mid-instruction, honoured at the boundary
        sc_clr = 1'b1; tick(); sc_clr = 1'b0;
        tick(); chk("halt_pre_sc1", int'(sc), 1);
        halt_req = 1'b1; tick(); halt_req = 1'b0;
        tick(); chk("halt_pre_sc3", int'(sc), 3);
        sc_clr = 1'b1; tick(); sc_clr = 1'b0;
        chk("halt_halted", int'(halted), 1);
        chk("halt_sc", int'(sc), 0);
        chk("halt_icount", int'(instr_count), 3);
        sc_clr = 1'b1; tick(); sc_clr = 1'b0;
        chk("halt_idle_sc", int'(sc), 0);
        chk("halt_idle_icount", int'(instr_count), 3);
        chk("halt_idle_fetch", int'(fetch), 0);

        // Single step of a three-T-state instruction
        step_req = 1'b1; tick(); step_req = 1'b0;
        chk("step_fetch", int'(fetch), 1);
        chk("step_halted", int'(halted), 0);
        tick(); tick();
        chk("step_sc2", int'(sc), 2);
        sc_clr = 1'b1; tick(); sc_clr = 1'b0;
        chk("step_done_halted", int'(halted), 1);
        chk("step_done_icount", int'(instr_count), 4);
        tick(); chk("step_idle_sc", int'(sc), 0);

        // Wrap from T7 without clear, then wrap the instruction counter
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        chk("wrap_sc7", int'(sc), 7);
        chk("wrap_err_before", int'(sc_err), 0);
        tick();
        chk("wrap_sc0", int'(sc), 0);
        chk("wrap_err", int'(sc_err), 1);
        chk("wrap_icount", int'(instr_count), 5);
        sc_clr = 1'b1;
        guard = 0;
        while (m_cnt != 16'hFFFF && guard < 70000) begin
            tick();
            guard++;
        end
        if (guard >= 70000) begin
            n_tests++; n_fail++;
            $display("FAIL icount_wait: budget expired, count %0d required 65535", instr_count);
        end
        chk("icount_ffff", int'(instr_count), 16'hFFFF);
        tick();
        sc_clr = 1'b0;
        chk("icount_wrap0", int'(instr_count), 0);
        chk("icount_err_sticky", int'(sc_err), 1);

        // Reset during a stall at T5
        for (int i = 0; i < 5; i++) tick();
        chk("rst_pre_sc5", int'(sc), 5);
        mem_busy = 1'b1; mem_ready = 1'b0;
        tick(); chk("rst_stall_sc5", int'(sc), 5);
        rst = 1'b1; tick(); rst = 1'b0; mem_busy = 1'b0;
        chk_reset_values("rst_stall");

        // Randomized traffic, checked by the compare process
        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(0, 199) == 0);
            start     = ($urandom_range(0, 7) == 0);
            halt_req  = ($urandom_range(0, 11) == 0);
            step_req  = ($urandom_range(0, 7) == 0);
            sc_clr    = ($urandom_range(0, 3) == 0);
            mem_busy  = ($urandom_range(0, 2) == 0);
            mem_ready = ($urandom_range(0, 1) == 0);
            tick();
        end
        rst = 1'b0; start = 1'b0; halt_req = 1'b0; step_req = 1'b0;
        sc_clr = 1'b0; mem_busy = 1'b0; mem_ready = 1'b0;
        tick(); tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
